dmem_block_latency: RTL

Parametrised block-organised data memory serving the data cache on its refill/write-back side. Whole blocks of `WORDS_PER_BLOCK` 32-bit words are transferred per access. Access latency is produced by a synchronous cycle counter rather than simulation delays. A busywait handshake stalls the cache controller until the access completes, and simultaneous read and write requests are rejected with an error flag.

---
 rtl/dmem_block_latency.sv | 104 ++++++++++
 1 files changed

// File: rtl/dmem_block_latency.sv
// Block-organised data memory for the data-cache refill/write-back side.
// A cycle counter models the access latency, and busywait stalls the cache until the access completes.
module dmem_block_latency #(
  parameter int unsigned BLOCK_ADDR_WIDTH = 6,
  parameter int unsigned WORDS_PER_BLOCK  = 1,
  parameter int unsigned LATENCY          = 5
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            read,
  input  logic                            write,
  input  logic [BLOCK_ADDR_WIDTH-1:0]     address,
  input  logic [32*WORDS_PER_BLOCK-1:0]   writedata,
  output logic [32*WORDS_PER_BLOCK-1:0]   readdata,
  output logic                            busywait,
  output logic                            error
);

  localparam int unsigned BLOCK_W         = 32 * WORDS_PER_BLOCK;
  localparam int unsigned BYTES_PER_BLOCK = 4 * WORDS_PER_BLOCK;
  localparam int unsigned OFF_W           = $clog2(BYTES_PER_BLOCK);
  localparam int unsigned BYTE_IDX_W      = BLOCK_ADDR_WIDTH + OFF_W;
  localparam int unsigned NUM_BYTES       = 1 << BYTE_IDX_W;
  localparam int unsigned CNT_W           = $clog2(LATENCY) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        op_write_q;
  logic [BLOCK_ADDR_WIDTH-1:0] addr_q;
  logic [BLOCK_W-1:0]          wdata_q;
  logic [7:0]                  mem [NUM_BYTES];

  logic accept;
  logic conflict;
  logic complete;

  assign accept   = (state_q == S_IDLE) && (read ^ write);
  assign conflict = (state_q == S_IDLE) && read && write;
  assign complete = (state_q == S_BUSY) && (cnt_q == '0);

  // Only read/write reach an output combinationally, and only while idle
  assign busywait = (state_q == S_BUSY) || ((state_q == S_IDLE) && (read ^ write));

  // State and latency counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, block storage and registered outputs; reset aborts any in-flight access
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      readdata   <= '0;
      error      <= 1'b0;
      for (int unsigned i = 0; i < NUM_BYTES; i++) mem[i] <= 8'h00;
    end else begin
      error <= conflict;
      if (accept) begin
        op_write_q <= write;
        addr_q     <= address;
        wdata_q    <= writedata;
      end
      if (complete) begin
        for (int unsigned b = 0; b < BYTES_PER_BLOCK; b++) begin
          if (op_write_q) mem[{addr_q, OFF_W'(b)}] <= wdata_q[8*b +: 8];
          else            readdata[8*b +: 8]       <= mem[{addr_q, OFF_W'(b)}];
        end
      end
    end
  end

endmodule
